seq_mult_param: RTL
===================

Name: seq_mult_param

Overview:
Parametrised successor to the 8-bit lab multiplier datapath: a WIDTH-bit sequential add-shift multiplier with signed/unsigned mode. Register B holds the multiplier and S holds the multiplicand; the 2*WIDTH-bit product accumulates in {A,B}, with X as the extension bit. It sits between the switch/button input logic (Din, Execute, ClearXA_LoadB) and the hex display drivers. Compared with the 8-bit block it adds:
- S captured at start
- automatic A/X clear on Execute
- Busy/Done status
- unsigned mode

Parameters:
WIDTH, 8, operand width in bits (valid 4..32).

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Din  input  WIDTH  operand input (loaded into B, or captured as S)
ClearXA_LoadB  input  1  level; in IDLE loads B<=Din and clears A, X
Execute  input  1  level; in IDLE starts a multiply
SignedMode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at start
Aval  output  WIDTH  register A (product high half)
Bval  output  WIDTH  register B (product low half)
X  output  1  extension/sign bit
M  output  1  current multiplier bit, equals B[0]
Busy  output  1  high in ADD and SHIFT states
Done  output  1  high in HOLD state

Behaviour:
- Reset, asynchronous: A, B, X, S, count and mode are all zero; state = IDLE; Busy = 0, Done = 0, M = 0. Reset mid-operation aborts immediately; no partial result is retained.
- States: IDLE, ADD, SHIFT, HOLD.
- IDLE, ClearXA_LoadB = 1: B<=Din, A<=0, X<=0. This has priority over Execute in the same cycle, which is ignored that cycle.
- IDLE, Execute = 1 and ClearXA_LoadB = 0: S<=Din, mode<=SignedMode, A<=0, X<=0, count<=0, go to ADD.
- ADD, count < WIDTH-1, M = 1: {X,A} <= ext(A) + ext(S), where ext is sign-extension (signed) or zero-extension (unsigned) to WIDTH+1 bits.
- ADD, count = WIDTH-1, M = 1:
  - Signed: {X,A} <= ext(A) - ext(S).
  - Unsigned: add as above.
- ADD, M = 0: registers hold.
- ADD always goes to SHIFT.
- SHIFT: {X,A,B} shifted right one bit.
  - Signed: X is replicated into the MSB (arithmetic shift).
  - Unsigned: 0 enters X.
  - count++. If count reaches WIDTH, go to HOLD; else go to ADD.
- HOLD: Done = 1; all registers hold. Go to IDLE when Execute = 0, so one button press yields exactly one multiply.
- Latency: Done asserts 2*WIDTH rising edges after the start edge (16 for WIDTH = 8).
- Ignored inputs: ClearXA_LoadB and Execute during ADD/SHIFT. Din changes after start have no effect (S is latched).
- Result: {A,B} = S*B_initial as a 2*WIDTH-bit two's-complement product (signed) or unsigned product. In signed mode X equals the product sign. In unsigned mode X = 0 at HOLD.
- Repeat: Execute from IDLE after HOLD uses the current B, i.e. the previous product's low half, as the new multiplier. A is always re-cleared.
- The adder is WIDTH+1 bits wide with no overflow loss. The most-negative operand is handled correctly because of the extension bit.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] mult_state_t {IDLE, ADD, SHIFT, HOLD}
  - function cnt_w(WIDTH) = $clog2(WIDTH)+1
- Sub-module add_sub_ext: parameter WIDTH; inputs A, S, Sub, SignedMode; output [WIDTH:0] sum. Purely combinational (WIDTH+1)-bit extend-and-add/subtract.
- The top contains the FSM, counter, and the A/B/X/S registers.

Test Plan:
1. WIDTH = 8, signed: load B = 0xC5 (-59), Din = 0x07, Execute -> Done after 16 edges; A = 0xFE, B = 0x5D, X = 1 (-413). Changing Din during Busy does not alter the result.
2. WIDTH = 8, signed: B = 0x80, S = 0x80 -> A = 0x40, B = 0x00, X = 0 (+16384). Then B = 0xFF, S = 0x01 -> A = 0xFF, B = 0xFF, X = 1.
3. WIDTH = 8, unsigned: B = 0xFF, S = 0xFF -> A = 0xFE, B = 0x01, X = 0 (65025). Same operands signed -> A = 0x00, B = 0x01.
4. WIDTH = 16, signed: B = 0xFFFF, S = 0x8000 -> A = 0x0000, B = 0x8000, X = 0. Done arrives exactly 32 edges after start.
5. Execute held high through HOLD -> no second run, Done stays 1. Releasing Execute returns to IDLE. ClearXA_LoadB together with Execute in IDLE -> load occurs and no start that cycle.
6. Assert Reset at count = 3 -> all outputs 0 immediately, state IDLE. A subsequent normal run gives the correct product.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential add-shift multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } mult_state_t;

  // Counter must reach WIDTH itself, hence one bit beyond $clog2.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/add_sub_ext.sv
// (WIDTH+1)-bit extend-and-add/subtract; the extra bit keeps the full result,
// including the most-negative operand case.
module add_sub_ext #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] S,
  input  logic             Sub,
  input  logic             SignedMode,
  output logic [WIDTH:0]   sum
);

  function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] v,
                                                input logic is_signed);
    return {is_signed & v[WIDTH-1], v};
  endfunction

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] s_ext;
  logic signed [WIDTH:0] res;

  always_comb begin
    a_ext = ext(A, SignedMode);
    s_ext = ext(S, SignedMode);
    res   = Sub ? (a_ext - s_ext) : (a_ext + s_ext);
    sum   = res;
  end

endmodule

// File: rtl/seq_mult_param.sv
// WIDTH-bit sequential add-shift multiplier, signed or unsigned; product
// accumulates in {A,B} with X as the extension bit.
import mult_pkg::*;

module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             ClearXA_LoadB,
  input  logic             Execute,
  input  logic             SignedMode,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             M,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  mult_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             x_q, mode_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc;
  logic             sub;
  logic [WIDTH:0]   sum;

  assign cnt_inc = cnt_q + 1'b1;
  // The last multiplier bit carries negative weight in two's complement.
  assign sub     = mode_q & (cnt_q == LAST_BIT);

  add_sub_ext #(.WIDTH(WIDTH)) u_add_sub (
    .A          (a_q),
    .S          (s_q),
    .Sub        (sub),
    .SignedMode (mode_q),
    .sum        (sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ClearXA_LoadB && Execute) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = (cnt_inc == FULL_CNT) ? HOLD : ADD;
      HOLD:    if (!Execute) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      x_q    <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ClearXA_LoadB) begin
            b_q <= Din;
            a_q <= '0;
            x_q <= 1'b0;
          end else if (Execute) begin
            s_q    <= Din;
            mode_q <= SignedMode;
            a_q    <= '0;
            x_q    <= 1'b0;
            cnt_q  <= '0;
          end
        end
        ADD: begin
          if (b_q[0]) {x_q, a_q} <= sum;
        end
        SHIFT: begin
          {x_q, a_q, b_q} <= {mode_q & x_q, x_q, a_q, b_q[WIDTH-1:1]};
          cnt_q           <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign M    = b_q[0];
  assign Busy = (state_q == ADD) || (state_q == SHIFT);
  assign Done = (state_q == HOLD);

endmodule
